// File: rtl/level_pkg.sv
// Shared types and widths for the level runner: state/phase codes and
// the score, lives and frame-time field widths.
package level_pkg;

    localparam int SCORE_W = 8;
    localparam int LIVES_W = 2;
    localparam int TIME_W  = 11;
    localparam int PHASE_W = 3;

    localparam logic [PHASE_W-1:0] PHASE_IDLE  = 3'b000;
    localparam logic [PHASE_W-1:0] PHASE_INTRO = 3'b001;
    localparam logic [PHASE_W-1:0] PHASE_PLAY  = 3'b010;
    localparam logic [PHASE_W-1:0] PHASE_WIN   = 3'b011;
    localparam logic [PHASE_W-1:0] PHASE_LOSE  = 3'b100;

    typedef enum logic [PHASE_W-1:0] {
        S_IDLE  = PHASE_IDLE,
        S_INTRO = PHASE_INTRO,
        S_PLAY  = PHASE_PLAY,
        S_WIN   = PHASE_WIN,
        S_LOSE  = PHASE_LOSE
    } state_e;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

endpackage

// File: rtl/level_runner_if.sv
// Sequencer <-> level runner signal bundle. The sequencer (master) drives
// the level request and game events; the runner (slave) reports status.
interface level_runner_if;
    import level_pkg::*;

    logic               level_start;
    logic               frame_tick;
    logic               hit;
    logic               miss;
    logic               level_done;
    logic               level_failed;
    logic [PHASE_W-1:0] phase;
    logic [SCORE_W-1:0] score;
    logic [LIVES_W-1:0] lives;
    logic [TIME_W-1:0]  time_left;

    modport master (
        output level_start, frame_tick, hit, miss,
        input  level_done, level_failed, phase, score, lives, time_left
    );

    modport slave (
        input  level_start, frame_tick, hit, miss,
        output level_done, level_failed, phase, score, lives, time_left
    );

endinterface

// File: rtl/frame_counter.sv
// Loadable down-counter of frame ticks; tc flags the enable that takes the
// count from 1 to 0, so the owner can react on that same edge.
module frame_counter #(
    parameter int WIDTH = 11
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (enable && count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;
    assign tc    = enable && (count_q == WIDTH'(1));

endmodule

// File: rtl/level_runner.sv
// Single-level game FSM: intro countdown, scoring/lives during play, and a
// held win/lose result. Optional PLAY time limit under `LEVEL_TIMEOUT_EN.
module level_runner
    import level_pkg::*;
#(
    parameter int TARGET_SCORE      = 10,
    parameter int INTRO_FRAMES      = 60,
    parameter int START_LIVES       = 3,
    parameter int TIME_LIMIT_FRAMES = 1800
) (
    input logic           Clk,
    input logic           reset,
    level_runner_if.slave bus
);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               done_q, done_d;
    logic               failed_q, failed_d;

    logic              intro_clr, intro_ld, intro_en, intro_tc;
    logic [TIME_W-1:0] intro_cnt;
    logic              tmr_clr, tmr_ld, tmr_en, tmr_tc;

    frame_counter #(.WIDTH(TIME_W)) u_intro_cnt (
        .Clk      (Clk),
        .reset    (reset),
        .clear    (intro_clr),
        .enable   (intro_en),
        .load     (intro_ld),
        .load_val (TIME_W'(INTRO_FRAMES)),
        .count    (intro_cnt),
        .tc       (intro_tc)
    );

    // Only the terminal flag matters for the intro; the count itself is not observed.
    logic unused_intro_cnt;
    assign unused_intro_cnt = ^intro_cnt;

`ifdef LEVEL_TIMEOUT_EN
    logic [TIME_W-1:0] tmr_cnt;

    frame_counter #(.WIDTH(TIME_W)) u_play_tmr (
        .Clk      (Clk),
        .reset    (reset),
        .clear    (tmr_clr),
        .enable   (tmr_en),
        .load     (tmr_ld),
        .load_val (TIME_W'(TIME_LIMIT_FRAMES)),
        .count    (tmr_cnt),
        .tc       (tmr_tc)
    );

    assign bus.time_left = tmr_cnt;
`else
    // No time limit: the timer controls go nowhere and expiry never fires.
    logic [TIME_W+2:0] unused_tmr;
    assign unused_tmr    = {TIME_W'(TIME_LIMIT_FRAMES), tmr_clr, tmr_ld, tmr_en};
    assign tmr_tc        = 1'b0;
    assign bus.time_left = '0;
`endif

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        lives_d   = lives_q;
        intro_clr = 1'b0;
        intro_ld  = 1'b0;
        intro_en  = 1'b0;
        tmr_clr   = 1'b0;
        tmr_ld    = 1'b0;
        tmr_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmr_clr   = 1'b1;
                intro_clr = !bus.level_start;
                if (bus.level_start) begin
                    state_d  = S_INTRO;
                    score_d  = '0;
                    lives_d  = LIVES_W'(START_LIVES);
                    intro_ld = 1'b1;
                end
            end
            S_INTRO: begin
                if (!bus.level_start) begin
                    state_d = S_IDLE;
                end else begin
                    intro_en = bus.frame_tick;
                    if (intro_tc) begin
                        state_d = S_PLAY;
                        tmr_ld  = 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (!bus.level_start) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_en = bus.frame_tick;
                    if (bus.hit && score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
                    if (bus.miss && lives_q != '0)       lives_d = lives_q - LIVES_W'(1);
                    // Win is checked first so a same-cycle win beats any loss cause.
                    if (score_d >= SCORE_W'(TARGET_SCORE))  state_d = S_WIN;
                    else if (lives_d == '0 || tmr_tc)       state_d = S_LOSE;
                end
            end
            S_WIN, S_LOSE: begin
                if (!bus.level_start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        done_d   = (state_d == S_WIN);
        failed_d = (state_d == S_LOSE);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            score_q  <= '0;
            lives_q  <= '0;
            done_q   <= 1'b0;
            failed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            done_q   <= done_d;
            failed_q <= failed_d;
        end
    end

    assign bus.phase        = state_q;
    assign bus.score        = score_q;
    assign bus.lives        = lives_q;
    assign bus.level_done   = done_q;
    assign bus.level_failed = failed_q;

endmodule

// File: doc/level_runner.md
LEVEL_RUNNER -- requirements
Module: level_runner

Interface
REQ-001 SHALL have parameter TARGET_SCORE, default 10, hits required to win the level.
REQ-002 SHALL have parameter INTRO_FRAMES, default 60, frame ticks spent in the intro phase.
REQ-003 SHALL have parameter START_LIVES, default 3, lives loaded at level entry (1..3).
REQ-004 SHALL have parameter TIME_LIMIT_FRAMES, default 1800, PLAY time limit in frame ticks (used only with LEVEL_TIMEOUT_EN).
REQ-005 SHALL have port Clk  input  1  system clock.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port level_start  input  1  level-active request from the game sequencer, held high for the whole level.
REQ-008 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-009 SHALL have port hit  input  1  one-cycle pulse: player scored.
REQ-010 SHALL have port miss  input  1  one-cycle pulse: player lost a life.
REQ-011 SHALL have port level_done  output  1  level won, held until level_start falls.
REQ-012 SHALL have port level_failed  output  1  level lost, held until level_start falls.
REQ-013 SHALL have port phase  output  3  current state encoding for the screen mux.
REQ-014 SHALL have port score  output  8  hits this level.
REQ-015 SHALL have port lives  output  2  remaining lives.
REQ-016 SHALL have port time_left  output  11  remaining PLAY frames.

Function
REQ-017 SHALL implement states IDLE=000, INTRO=001, PLAY=010, WIN=011, LOSE=100; phase SHALL equal the state code.
REQ-018 IDLE: level_start high -> INTRO next cycle; score cleared, lives loaded with START_LIVES, intro/time counters cleared.
REQ-019 INTRO: count frame_tick; on the INTRO_FRAMES-th tick -> PLAY next cycle; hit/miss ignored.
REQ-020 PLAY: hit increments score, saturating at 255; miss decrements lives, never below 0.
REQ-021 PLAY: the cycle after score reaches TARGET_SCORE -> WIN; the cycle after lives reaches 0 -> LOSE.
REQ-022 Simultaneous hit and miss in PLAY: both applied the same cycle; if both win and lose conditions result, WIN SHALL take priority.
REQ-023 WIN: level_done=1; LOSE: level_failed=1; both outputs are 0 in all other states and never high together.
REQ-024 WIN/LOSE: score and lives frozen; level_start low -> IDLE next cycle.
REQ-025 level_start low in INTRO or PLAY (abort) -> IDLE next cycle, no done/failed pulse.
REQ-026 All outputs registered; state change visible one cycle after the causing input.

Reset
REQ-027 reset SHALL take priority over all inputs and force state IDLE, score=0, lives=0, time_left=0, level_done=0, level_failed=0, phase=000.
REQ-028 reset asserted mid-level SHALL abort it without asserting level_done or level_failed.

Configuration
REQ-029 Macro LEVEL_TIMEOUT_EN defined: time_left loads TIME_LIMIT_FRAMES on INTRO->PLAY, decrements per frame_tick in PLAY, and reaching 0 -> LOSE next cycle; WIN has priority over timeout in the same cycle.
REQ-030 Macro LEVEL_TIMEOUT_EN undefined: no time limit, time_left tied to 0, timer logic absent.

Structure
REQ-031 Package level_pkg SHALL hold the state enum, the phase code constants and the score/lives/time widths.
REQ-032 Sub-module frame_counter (clear, enable on frame_tick, load value, terminal-count flag) SHALL implement both the intro counter and the PLAY timer.

Verification
REQ-033 reset, then level_start=1 and 60 frame_ticks -> phase 000->001->010 exactly one cycle after the 60th tick.
REQ-034 PLAY, 10 hits -> score=10, phase=011, level_done=1 held; drop level_start -> IDLE, level_done=0 next cycle.
REQ-035 PLAY, 3 misses -> lives 3->0, phase=100, level_failed=1; further hit leaves score unchanged.
REQ-036 PLAY with score=9, lives=1, hit and miss in the same cycle -> score=10, lives=0, WIN, level_failed=0.
REQ-037 level_start falls mid-PLAY with score=5 -> IDLE next cycle; re-raise -> score=0, lives=3.
REQ-038 LEVEL_TIMEOUT_EN, TIME_LIMIT_FRAMES=5, no hits -> time_left 5->0, then LOSE; undefined -> stays in PLAY, time_left=0.
